load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's execute/mem stage and the word-wide data memory.
//  Converts RISC-V byte/halfword/word loads and stores into 32-bit word accesses.
//  Performs read-modify-write for sub-word stores and sign/zero extension for loads.
//  Flags misaligned, illegal and out-of-range accesses back to the core.
// PARAMETERS
//  MEM_AW  11    word-address width driven to data memory
//  DEPTH   1028  number of 32-bit words in data memory; word index >= DEPTH is out of range
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rstn        in   1   asynchronous, active-low reset
//  i_req_valid   in   1   core request valid
//  o_req_ready   out  1   LSU can accept request this cycle
//  i_req_we      in   1   1 = store, 0 = load
//  i_req_funct3  in   3   RISC-V funct3 (size/sign)
//  i_req_addr    in   32  byte address
//  i_req_wdata   in   32  store data (right-aligned)
//  o_rsp_valid   out  1   one-cycle completion pulse
//  o_rsp_rdata   out  32  extended load data (0 for stores/errors)
//  o_rsp_err     out  1   access rejected (qualified by o_rsp_valid)
//  o_mem_write   out  1   data memory write enable
//  o_mem_addr    out  MEM_AW  word address = i_req_addr[MEM_AW+1:2] or held RMW address
//  o_mem_wdata   out  32  word to write
//  i_mem_rdata   in   32  combinational read data for o_mem_addr
// BEHAVIOUR
//  Reset: state=IDLE, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_mem_write=0, held regs=0.
//  States: IDLE, MERGE. o_req_ready = (state==IDLE). Accept = i_req_valid & o_req_ready.
//  Legal funct3: loads 000 LB,001 LH,010 LW,100 LBU,101 LHU; stores 000 SB,001 SH,010 SW.
//  Error if: illegal funct3, or i_req_addr[31:MEM_AW+2]!=0, or word index >= DEPTH,
//   or misaligned (see CONFIGURATION). Error access: no memory write;
//   next cycle o_rsp_valid=1, o_rsp_err=1, o_rsp_rdata=0; stays IDLE.
//  Load (IDLE, accepted): o_mem_addr from request; select byte/half by addr[1:0]/addr[1];
//   sign-extend (LB/LH) or zero-extend (LBU/LHU); result registered -> o_rsp_valid next cycle.
//   Latency 1.
//  SW (IDLE, accepted): o_mem_write=1 same cycle, o_mem_wdata=i_req_wdata; rsp next cycle. Latency 1.
//  SB/SH (IDLE, accepted): latch i_mem_rdata, word addr, lanes, data; go MERGE.
//   MERGE: o_mem_addr=held addr, o_mem_write=1, o_mem_wdata = old word with selected
//   byte/half lanes replaced by i_req_wdata[7:0]/[15:0]; go IDLE; rsp next cycle. Latency 2.
//  o_mem_write is 0 in every other cycle; o_mem_addr/o_mem_wdata don't-care when idle.
//  Back-to-back: a new request is accepted in the same cycle o_rsp_valid pulses for the prior one.
//  Requests presented in MERGE are not accepted; core must hold them stable.
//  Reset asserted in MERGE: pending write is dropped, no rsp issued, memory unchanged by LSU.
//  o_rsp_rdata for stores is 0; o_rsp_err=0 on successful responses.
// CONFIGURATION
//  LSU_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0
//   -> error response as above.
//  Not defined: misalignment is not checked; low address bits are truncated
//   (half uses addr[1], word ignores addr[1:0]); access proceeds normally, no error.
// TESTING
//  1 Reset mid-MERGE (SB in flight) -> outputs at reset values, no o_mem_write, target word unchanged.
//  2 SW addr 0x10 data 0xDEADBEEF; LW 0x10 -> o_mem_write pulse at word 4; rsp rdata 0xDEADBEEF,
//    latency 1 each.
//  3 word 4 = 0xDEADBEEF; SB 0x11 data 0x55 -> MERGE writes 0xDEAD55EF, ready low 1 cycle,
//    rsp after 2 cycles.
//  4 word 4 = 0xDEAD55EF: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD;
//    LHU 0x10 -> 0x000055EF.
//  5 LW 0x1010 (word 1028) and funct3=011 -> rsp err=1, rdata=0, no write;
//    LW 0x1FF0 (word 2044) -> err=1.
//  6 LW 0x12: with LSU_MISALIGN_CHECK_EN -> err=1; without -> err=0, rdata = word 4.
//    Back-to-back SW,LW on consecutive cycles -> both accepted, two rsp pulses.

Source files
------------

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Bridges RISC-V byte/half/word loads and stores onto a 32-bit
//               word-wide data memory. Sub-word stores use a two-cycle
//               read-modify-write; loads are sign/zero extended. Misaligned,
//               illegal and out-of-range accesses return an error response.
//               Optional macro LSU_MISALIGN_CHECK_EN enables misalignment
//               errors; without it the low address bits are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_AW = 11,
    parameter int DEPTH  = 1028
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_write,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_MERGE = 1'b1
    } state_t;

    localparam logic [2:0]  c_F3_B  = 3'b000;
    localparam logic [2:0]  c_F3_H  = 3'b001;
    localparam logic [2:0]  c_F3_W  = 3'b010;
    localparam logic [2:0]  c_F3_BU = 3'b100;
    localparam logic [2:0]  c_F3_HU = 3'b101;
    localparam logic [31:0] c_DEPTH = 32'(DEPTH);

    state_t            r_state;
    logic [MEM_AW-1:0] r_addr;
    logic [31:0]       r_old;
    logic [15:0]       r_data;
    logic [1:0]        r_lane;
    logic              r_half;
    logic              r_rsp_valid;
    logic [31:0]       r_rsp_rdata;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_f3_ok;
    logic              w_hi_err;
    logic              w_range_err;
    logic              w_misalign;
    logic              w_err;
    logic [MEM_AW-1:0] w_word_idx;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_accept    = i_req_valid & o_req_ready;
    assign w_word_idx  = i_req_addr[MEM_AW+1:2];
    assign w_hi_err    = |i_req_addr[31:MEM_AW+2];
    assign w_range_err = ({{(32-MEM_AW){1'b0}}, w_word_idx} >= c_DEPTH);
    assign w_err       = ~w_f3_ok | w_hi_err | w_range_err | w_misalign;

    // Legal size/sign encodings differ between loads and stores
    always_comb begin
        w_f3_ok = 1'b0;
        if (i_req_we) begin
            w_f3_ok = (i_req_funct3 == c_F3_B) || (i_req_funct3 == c_F3_H) ||
                      (i_req_funct3 == c_F3_W);
        end else begin
            w_f3_ok = (i_req_funct3 == c_F3_B)  || (i_req_funct3 == c_F3_H) ||
                      (i_req_funct3 == c_F3_W)  || (i_req_funct3 == c_F3_BU) ||
                      (i_req_funct3 == c_F3_HU);
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // Halves must be 2-byte aligned, words 4-byte aligned
    always_comb begin
        w_misalign = 1'b0;
        case (i_req_funct3)
            c_F3_H, c_F3_HU: w_misalign = i_req_addr[0];
            c_F3_W:          w_misalign = |i_req_addr[1:0];
            default:         w_misalign = 1'b0;
        endcase
    end
`else
    assign w_misalign = 1'b0;
`endif

    // Lane selection and extension of the returned memory word
    always_comb begin
        w_byte      = 8'h00;
        w_load_data = 32'h0;
        case (i_req_addr[1:0])
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_req_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (i_req_funct3)
            c_F3_B:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_H:  w_load_data = {{16{w_half[15]}}, w_half};
            c_F3_W:  w_load_data = i_mem_rdata;
            c_F3_BU: w_load_data = {24'h0, w_byte};
            c_F3_HU: w_load_data = {16'h0, w_half};
            default: w_load_data = 32'h0;
        endcase
    end

    // Old word with the held byte/half lanes replaced by the store data
    always_comb begin
        w_merged = r_old;
        if (r_half) begin
            if (r_lane[1]) w_merged[31:16] = r_data;
            else           w_merged[15:0]  = r_data;
        end else begin
            case (r_lane)
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_mem_write = (r_state == S_MERGE) |
                         (w_accept & i_req_we & (i_req_funct3 == c_F3_W) & ~w_err);
    assign o_mem_addr  = (r_state == S_MERGE) ? r_addr : w_word_idx;
    assign o_mem_wdata = (r_state == S_MERGE) ? w_merged : i_req_wdata;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

    // Request sequencing, RMW capture and registered response
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_old       <= 32'h0;
            r_data      <= 16'h0;
            r_lane      <= 2'd0;
            r_half      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (!i_req_we) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_load_data;
                        end else if (i_req_funct3 == c_F3_W) begin
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= S_MERGE;
                            r_addr  <= w_word_idx;
                            r_old   <= i_mem_rdata;
                            r_data  <= i_req_wdata[15:0];
                            r_lane  <= i_req_addr[1:0];
                            r_half  <= (i_req_funct3 == c_F3_H);
                        end
                    end
                end
                S_MERGE: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit. A byte-level reference
//               model predicts responses and memory writes at issue time; a
//               negedge monitor pops and compares them as the DUT emits them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_AW = 11;
    localparam int DEPTH  = 1028;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'd0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_write;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem     [0:2047];
    logic [31:0] ref_mem [0:2047];

    typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
    typedef struct { logic [MEM_AW-1:0] addr; logic [31:0] data; int cyc; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    load_store_unit #(.MEM_AW(MEM_AW), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_we(req_we), .i_req_funct3(req_funct3),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed view of memory and the access rules
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int unsigned idx, off, nb, sh;
        logic [31:0] mask, w, v;
        bit err;
        rsp_t r;
        wr_t  wr;
        idx  = addr / 4;
        off  = addr % 4;
        nb   = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        mask = (nb == 1) ? 32'hFF : ((nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF);
        err  = 0;
        if (addr >= 32'h2000 || idx >= DEPTH) err = 1;
        if (we && f3 > 3'd2) err = 1;
        if (!we && (f3 == 3'd3 || f3 > 3'd5)) err = 1;
`ifdef LSU_MISALIGN_CHECK_EN
        if (off % nb != 0) err = 1;
`endif
        sh = 8 * (off - off % nb);
        r.rdata = 32'h0;
        r.err   = err;
        r.cyc   = cyc + ((we && nb < 4 && !err) ? 2 : 1);
        if (!err) begin
            w = ref_mem[idx];
            if (!we) begin
                v = (w >> sh) & mask;
                if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~mask;
                r.rdata = v;
            end else begin
                w = (w & ~(mask << sh)) | ((wd & mask) << sh);
                ref_mem[idx] = w;
                wr.addr = idx[MEM_AW-1:0];
                wr.data = w;
                wr.cyc  = cyc + ((nb == 4) ? 0 : 1);
                wr_q.push_back(wr);
            end
        end
        rsp_q.push_back(r);
    endtask

    // Present one request (entered just after a posedge), model it when accepted
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        int guard;
        guard      = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        while (!req_ready && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high addr=%h", addr);
        end else begin
            model(we, f3, addr, wd);
            @(posedge clk);
        end
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every response and every memory write must be expected
    always @(negedge clk) begin
        rsp_t r;
        wr_t  w;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp actual=valid required=none rdata=%h", rsp_rdata);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, r.rdata);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, r.err});
                chk("rsp_cycle", cyc, r.cyc);
            end
        end
        if (mem_write) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=addr %h required=none", mem_addr);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", {21'h0, mem_addr}, {21'h0, w.addr});
                chk("wr_data", mem_wdata, w.data);
                chk("wr_cycle", cyc, w.cyc);
            end
        end
    end

    initial begin
        logic [31:0] v;
        int guard;
        for (int i = 0; i < 2048; i++) begin
            v          = $urandom;
            mem[i]    <= v;
            ref_mem[i] = v;
        end
        #12;
        // Reset state
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        // Reset asserted while an SB is in its merge cycle
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h21; req_wdata = 32'hA5;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("merge_ready_low", {31'h0, req_ready}, 32'h0);
        rstn = 1'b0;
        #1;
        chk("rstm_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rstm_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rstm_rsp_rdata", rsp_rdata, 32'h0);
        chk("rstm_rsp_err", {31'h0, rsp_err}, 32'h0);
        idle(2);
        chk("rstm_word_kept", mem[8], ref_mem[8]);
        rstn = 1'b1;
        idle(1);

        // SW then LW at word 4
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        idle(2);
        // SB into byte 1 of word 4
        issue(1'b1, 3'b000, 32'h11, 32'h55);
        chk("sb_ready_low", {31'h0, req_ready}, 32'h0);
        idle(2);
        chk("sb_merged_word", mem[4], 32'hDEAD55EF);
        // Extension cases
        issue(1'b0, 3'b000, 32'h13, 32'h0);
        issue(1'b0, 3'b100, 32'h13, 32'h0);
        issue(1'b0, 3'b001, 32'h12, 32'h0);
        issue(1'b0, 3'b101, 32'h10, 32'h0);
        // Range and illegal encodings
        issue(1'b0, 3'b010, 32'h1010, 32'h0);
        issue(1'b0, 3'b011, 32'h10, 32'h0);
        issue(1'b0, 3'b010, 32'h1FF0, 32'h0);
        issue(1'b1, 3'b010, 32'h1010, 32'h12345678);
        issue(1'b0, 3'b010, 32'h100C, 32'h0);
        issue(1'b0, 3'b010, 32'h2000, 32'h0);
        // Misalignment and back-to-back
        issue(1'b0, 3'b010, 32'h12, 32'h0);
        issue(1'b1, 3'b001, 32'h17, 32'hBEEF);
        issue(1'b1, 3'b010, 32'h40, 32'h0BADF00D);
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        idle(1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = $urandom_range(0, 63);
            else if (sel < 9) a = $urandom_range(32'h1000 - 16, 32'h1000 + 31);
            else              a = $urandom;
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        // Drain outstanding expectations within a bounded window
        guard = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        idle(2);
        if (rsp_q.size() != 0 || wr_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", rsp_q.size() + wr_q.size());
        end
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
